// File: rtl/gpio_reg_arb_pkg.sv
// Shared types and default timing for the GPIO/ADC register-bus arbiter.
// The cycle counter is 4 bits, so both timing parameters must stay within 1..15.
package gpio_reg_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_t;

    localparam int DEF_STROBE_CYCLES = 3;
    localparam int DEF_WAIT_CYCLES   = 4;
    localparam int CNT_W             = 4;

endpackage

// File: rtl/gpio_reg_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins; on contention the
// requester that did not win last time is chosen.
module rr_arb2 (
    input  logic       reg_clk,
    input  logic       reset_in,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_idx,
    output logic       grant_valid
);

    logic last_grant_reg;

    always_comb begin
        grant_valid = |req;
        if (&req) begin
            grant_idx = ~last_grant_reg;
        end else begin
            grant_idx = req[1];
        end
    end

    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            last_grant_reg <= 1'b0;
        end else if (grant_en && grant_valid) begin
            last_grant_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/gpio_reg_arbiter.sv
// Arbitrates two masters onto the GPIO/ADC register decoder bus with fixed
// strobe and wait timing; every bus-facing output is a flop.
module gpio_reg_arbiter
    import gpio_reg_arb_pkg::*;
#(
    parameter int AddrWidth    = 16,
    parameter int BusWidth     = 32,
    parameter int StrobeCycles = DEF_STROBE_CYCLES,
    parameter int WaitCycles   = DEF_WAIT_CYCLES
) (
    input  logic                      reg_clk,
    input  logic                      reset_in,
    input  logic [1:0]                m_req,
    input  logic [1:0]                m_wr,
    input  logic [1:0][AddrWidth-1:2] m_addr,
    input  logic [1:0][BusWidth-1:0]  m_wdata,
    output logic [1:0]                m_ack,
    output logic [BusWidth-1:0]       m_rdata,
    output logic                      chip_sel,
    output logic                      write_reg,
    output logic                      read_reg,
    output logic [AddrWidth-1:2]      busaddress,
    output logic [BusWidth-1:0]       busdata_in,
    input  logic [BusWidth-1:0]       busdata_to_cpu,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(StrobeCycles - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(WaitCycles - 1);

    arb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             dir_reg, dir_next;
    logic             grant_reg;
    logic             grant_en, grant_idx, grant_valid;

    rr_arb2 u_rr_arb2 (
        .reg_clk     (reg_clk),
        .reset_in    (reset_in),
        .req         (m_req),
        .grant_en    (grant_en),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Counter is reloaded on each state entry and only decrements while non-zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        grant_en   = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (grant_valid) begin
                    state_next = ST_ISSUE;
                    cnt_next   = STROBE_LOAD;
                    grant_en   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (cnt_reg == '0) begin
                    state_next = ST_WAIT;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_ACK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_ACK: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign dir_next = grant_en ? m_wr[grant_idx] : dir_reg;

    always_ff @(posedge reg_clk or posedge reset_in) begin
        if (reset_in) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            dir_reg    <= 1'b0;
            grant_reg  <= 1'b0;
            busaddress <= '0;
            busdata_in <= '0;
            m_rdata    <= '0;
            m_ack      <= '0;
            write_reg  <= 1'b0;
            read_reg   <= 1'b0;
            chip_sel   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            dir_reg   <= dir_next;
            if (grant_en) begin
                grant_reg  <= grant_idx;
                busaddress <= m_addr[grant_idx];
                busdata_in <= m_wdata[grant_idx];
            end
            if (state_reg == ST_WAIT && state_next == ST_ACK && !dir_reg) begin
                m_rdata <= busdata_to_cpu;
            end
            write_reg <= (state_next == ST_ISSUE) && dir_next;
            read_reg  <= (state_next == ST_ISSUE) && !dir_next;
            chip_sel  <= (state_next == ST_ISSUE) || (state_next == ST_WAIT);
            busy      <= (state_next != ST_IDLE);
            m_ack     <= (state_next == ST_ACK) ? {grant_reg, ~grant_reg} : 2'b00;
        end
    end

endmodule

// File: tb/tb_gpio_reg_arbiter.sv
// Directed bench: table of single accesses on the default instance, plus
// reset-abort, contention and timing-parameter sweep sequences.
module tb_gpio_reg_arbiter;

    logic              reg_clk = 1'b0;
    logic              reset_in = 1'b1;
    logic [1:0]        m_req = '0, req_f = '0, req_s = '0;
    logic [1:0]        m_wr = '0;
    logic [1:0][15:2]  m_addr = '0;
    logic [1:0][31:0]  m_wdata = '0;
    logic [31:0]       busdata_to_cpu = '0;

    logic [1:0]  m_ack, ack_f, ack_s;
    logic [31:0] m_rdata, rdata_f, rdata_s;
    logic        chip_sel, cs_f, cs_s;
    logic        write_reg, wr_f, wr_s;
    logic        read_reg, rd_f, rd_s;
    logic [15:2] busaddress, ba_f, ba_s;
    logic [31:0] busdata_in, bd_f, bd_s;
    logic        busy, busy_f, busy_s;

    int tests = 0;
    int fails = 0;

    always #5 reg_clk = ~reg_clk;

    gpio_reg_arbiter dut (
        .reg_clk(reg_clk), .reset_in(reset_in), .m_req(m_req), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata),
        .chip_sel(chip_sel), .write_reg(write_reg), .read_reg(read_reg),
        .busaddress(busaddress), .busdata_in(busdata_in),
        .busdata_to_cpu(busdata_to_cpu), .busy(busy)
    );

    gpio_reg_arbiter #(.StrobeCycles(1), .WaitCycles(1)) dut_fast (
        .reg_clk(reg_clk), .reset_in(reset_in), .m_req(req_f), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(ack_f), .m_rdata(rdata_f),
        .chip_sel(cs_f), .write_reg(wr_f), .read_reg(rd_f),
        .busaddress(ba_f), .busdata_in(bd_f),
        .busdata_to_cpu(busdata_to_cpu), .busy(busy_f)
    );

    gpio_reg_arbiter #(.StrobeCycles(15), .WaitCycles(15)) dut_slow (
        .reg_clk(reg_clk), .reset_in(reset_in), .m_req(req_s), .m_wr(m_wr),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(ack_s), .m_rdata(rdata_s),
        .chip_sel(cs_s), .write_reg(wr_s), .read_reg(rd_s),
        .busaddress(ba_s), .busdata_in(bd_s),
        .busdata_to_cpu(busdata_to_cpu), .busy(busy_s)
    );

    typedef struct {
        bit          idx;
        bit          wr;
        bit          withdraw;
        logic [13:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdv;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Default instance: strobe 3 cycles, wait 4, ack 8 cycles after the request cycle.
    task automatic run_vec(input string tag, input vec_t v);
        int strb = 0, opp = 0, first = -1, ackk = -1, cs = 0, wrong = 0;
        logic [31:0] rd = '0, ba = '0, bd = '0;
        logic strobe, other;
        @(negedge reg_clk);
        m_wr[v.idx] = v.wr; m_addr[v.idx] = v.addr; m_wdata[v.idx] = v.wdata;
        m_req[v.idx] = 1'b1;
        for (int k = 1; k <= 50 && ackk < 0; k++) begin
            @(negedge reg_clk);
            busdata_to_cpu = (k >= 4 && k <= 7) ? v.rdv : 32'hBAD0BAD0;
            if (v.withdraw && k == 1) begin
                m_req[v.idx] = 1'b0;
                m_addr[v.idx] = 14'h2AAA;
                m_wdata[v.idx] = ~v.wdata;
            end
            strobe = v.wr ? write_reg : read_reg;
            other  = v.wr ? read_reg : write_reg;
            if (strobe) begin
                strb++;
                if (first < 0) first = k;
                ba = 32'(busaddress);
                bd = busdata_in;
            end
            if (other) opp++;
            if (chip_sel) cs++;
            if (m_ack[!v.idx]) wrong++;
            if (m_ack[v.idx]) begin
                ackk = k;
                rd = m_rdata;
                m_req[v.idx] = 1'b0;
            end
        end
        check({tag, " strobe_width"}, strb, 3);
        check({tag, " strobe_start"}, first, 1);
        check({tag, " opposite_strobe"}, opp, 0);
        check({tag, " chip_sel_width"}, cs, 7);
        check({tag, " ack_latency"}, ackk, 8);
        check({tag, " wrong_ack"}, wrong, 0);
        check({tag, " busaddress"}, ba, 32'(v.addr));
        check({tag, " busdata_in"}, bd, v.wdata);
        check({tag, " m_rdata"}, rd, v.exp_rdata);
        $display("[TB] %s req%0d %s addr=0x%04h ack@%0d rdata=0x%08h",
                 tag, v.idx, v.wr ? "WR" : "RD", v.addr, ackk, rd);
    endtask

    task automatic run_sweep(input bit sel, input int s, input int w);
        int strb = 0, first = -1, ackk = -1;
        logic strobe;
        @(negedge reg_clk);
        m_wr[0] = 1'b1; m_addr[0] = 14'h0440; m_wdata[0] = 32'h5555AAAA;
        if (sel) req_s[0] = 1'b1; else req_f[0] = 1'b1;
        for (int k = 1; k <= 50 && ackk < 0; k++) begin
            @(negedge reg_clk);
            strobe = sel ? wr_s : wr_f;
            if (strobe) begin
                strb++;
                if (first < 0) first = k;
            end
            if (sel ? ack_s[0] : ack_f[0]) begin
                ackk = k;
                req_s[0] = 1'b0;
                req_f[0] = 1'b0;
            end
        end
        check($sformatf("sweep%0d strobe_width", s), strb, s);
        check($sformatf("sweep%0d strobe_start", s), first, 1);
        check($sformatf("sweep%0d ack_latency", s), ackk, 1 + s + w);
        $display("[TB] sweep S=%0d W=%0d strobe=%0d ack@%0d", s, w, strb, ackk);
    endtask

    initial begin
        int order[4];
        int ngr, overlap, gapviol, dual;
        int drop[2];
        bit prev_ack;

        vecs[0] = '{0, 1, 0, 14'h0440, 32'h00FFFFFF, 32'h0,        32'h00000000};
        vecs[1] = '{1, 0, 0, 14'h0448, 32'h0,        32'h03020100, 32'h03020100};
        vecs[2] = '{0, 0, 0, 14'h1234, 32'h0,        32'hA5A55A5A, 32'hA5A55A5A};
        vecs[3] = '{1, 1, 0, 14'h3FFF, 32'hFFFFFFFF, 32'h0,        32'hA5A55A5A};
        vecs[4] = '{0, 1, 1, 14'h0101, 32'h12345678, 32'h0,        32'hA5A55A5A};
        vecs[5] = '{1, 0, 1, 14'h0202, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D};

        // Reset state, with a request already pending.
        m_req = 2'b01;
        repeat (2) @(negedge reg_clk);
        check("rst write_reg", write_reg, 0);
        check("rst read_reg", read_reg, 0);
        check("rst chip_sel", chip_sel, 0);
        check("rst busy", busy, 0);
        check("rst m_ack", m_ack, 0);
        check("rst m_rdata", m_rdata, 0);
        check("rst busaddress", busaddress, 0);
        check("rst busdata_in", busdata_in, 0);
        m_req = 2'b00;
        reset_in = 1'b0;
        $display("[TB] reset state checked");

        for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

        // Reset during the second ISSUE cycle of a write.
        @(negedge reg_clk);
        m_wr[0] = 1'b1; m_addr[0] = 14'h0440; m_wdata[0] = 32'h00FFFFFF; m_req[0] = 1'b1;
        repeat (2) @(negedge reg_clk);
        check("abort strobe_before", write_reg, 1);
        reset_in = 1'b1;
        #1;
        check("abort write_reg", write_reg, 0);
        check("abort busy", busy, 0);
        check("abort chip_sel", chip_sel, 0);
        check("abort busaddress", busaddress, 0);
        check("abort busdata_in", busdata_in, 0);
        check("abort m_rdata", m_rdata, 0);
        m_req = 2'b00;
        repeat (2) @(negedge reg_clk);
        reset_in = 1'b0;
        ngr = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge reg_clk);
            if (m_ack != 2'b00 || busy) ngr++;
        end
        check("abort no_ack_after", ngr, 0);
        $display("[TB] reset mid-access checked");
        run_vec("post_abort", '{0, 1, 0, 14'h0440, 32'h00FFFFFF, 32'h0, 32'h00000000});

        // Both masters request continuously from reset.
        @(negedge reg_clk);
        reset_in = 1'b1;
        m_wr[0] = 1'b1; m_wr[1] = 1'b0;
        m_req = 2'b11;
        busdata_to_cpu = 32'h11112222;
        repeat (2) @(negedge reg_clk);
        reset_in = 1'b0;
        ngr = 0; overlap = 0; gapviol = 0; dual = 0; prev_ack = 0;
        drop[0] = 0; drop[1] = 0;
        for (int k = 0; k < 100 && ngr < 4; k++) begin
            @(negedge reg_clk);
            if (write_reg && read_reg) overlap++;
            if (prev_ack && busy) gapviol++;
            if (m_ack == 2'b11) dual++;
            prev_ack = |m_ack;
            for (int r = 0; r < 2; r++) begin
                if (drop[r] > 0) drop[r]--;
                if (m_ack[r]) begin
                    order[ngr] = r;
                    ngr++;
                    drop[r] = 2;
                end
                m_req[r] = (drop[r] == 0);
            end
        end
        m_req = 2'b00;
        check("rr grants", ngr, 4);
        check("rr order0", order[0], 1);
        check("rr order1", order[1], 0);
        check("rr order2", order[2], 1);
        check("rr order3", order[3], 0);
        check("rr overlap", overlap, 0);
        check("rr idle_gap", gapviol, 0);
        check("rr dual_ack", dual, 0);
        $display("[TB] contention order %0d %0d %0d %0d", order[0], order[1], order[2], order[3]);
        repeat (12) @(negedge reg_clk);

        run_sweep(1'b0, 1, 1);
        run_sweep(1'b1, 15, 15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_reg_arbiter.md
GPIO_REG_ARBITER -- requirements
Module: gpio_reg_arbiter

Interface
REQ-001 Parameter AddrWidth, default 16: register bus byte-address width; word address is [AddrWidth-1:2].
REQ-002 Parameter BusWidth, default 32: data width.
REQ-003 Parameter StrobeCycles, default 3: cycles read_reg/write_reg stay high per access (range 1..15).
REQ-004 Parameter WaitCycles, default 4: cycles after strobe deassert before read data is sampled (range 1..15).
REQ-005 reg_clk  in  1  register bus clock; all logic on the rising edge.
REQ-006 reset_in  in  1  reset; asynchronous, active-high.
REQ-007 m_req  in  2  per-requester access request (index 0 = HPS, index 1 = config loader); level, held until ack.
REQ-008 m_wr  in  2  per-requester direction: 1 write, 0 read; valid while m_req is high.
REQ-009 m_addr  in  2 x [AddrWidth-1:2]  per-requester word address.
REQ-010 m_wdata  in  2 x BusWidth  per-requester write data.
REQ-011 m_ack  out  2  one-cycle completion pulse to the granted requester.
REQ-012 m_rdata  out  BusWidth  read data, valid in the m_ack cycle only (shared by both requesters).
REQ-013 chip_sel  out  1  high from ISSUE entry through the end of WAIT.
REQ-014 write_reg / read_reg  out  1 each  access strobes to the GPIO/ADC register decoder.
REQ-015 busaddress  out  [AddrWidth-1:2]  latched address of the active access.
REQ-016 busdata_in  out  BusWidth  latched write data of the active access.
REQ-017 busdata_to_cpu  in  BusWidth  decoder read-data return.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, ACK; all outputs registered.
REQ-020 IDLE: if any m_req is high, grant one requester, latch its m_wr/m_addr/m_wdata into the direction/busaddress/busdata_in registers, and go to ISSUE; otherwise stay in IDLE.
REQ-021 Arbitration: round-robin over 2 requesters. last_grant pointer (reset 0) is updated on every grant. When both requests are high, grant ~last_grant. A single request is granted regardless of the pointer.
REQ-022 ISSUE: hold write_reg (write) or read_reg (read) high for exactly StrobeCycles cycles, then go to WAIT. The opposite strobe stays 0.
REQ-023 WAIT: both strobes low for exactly WaitCycles cycles, then go to ACK.
REQ-024 ACK: pulse m_ack[grant] for one cycle and return to IDLE.
  - Reads: m_rdata is loaded from busdata_to_cpu at the WAIT->ACK edge.
  - Writes: m_rdata holds its previous value.
REQ-025 Latency: request first seen high in IDLE at cycle N gives strobe high in cycles N+1..N+StrobeCycles and m_ack at cycle N+1+StrobeCycles+WaitCycles (defaults: N+8).
REQ-026 At least one IDLE cycle separates consecutive accesses, so the decoder always sees a strobe falling edge between accesses.
REQ-027 A requester must drop m_req in the cycle after m_ack. A request still high in the following IDLE cycle is a new access.
REQ-028 m_req dropped or changed after grant: the transaction completes with the latched values and m_ack is still issued.
REQ-029 One shared cycle counter, 4 bits wide, is reloaded on every state entry. It never wraps.

Reset
REQ-030 While reset_in is high, the following are held at 0: state=IDLE, strobes, chip_sel, busy, m_ack, m_rdata, busaddress, busdata_in, counter, last_grant.
REQ-031 Reset asserted mid-access aborts the access immediately: the strobe drops asynchronously and no m_ack is issued.
REQ-032 After reset release, the first grant occurs no earlier than the first rising edge at which m_req is sampled high.

Structure
REQ-033 Package gpio_reg_arb_pkg holds the state enum and the default StrobeCycles/WaitCycles constants.
REQ-034 One sub-module, rr_arb2: the 2-way round-robin grant logic with the last_grant register. The FSM and datapath stay in gpio_reg_arbiter.

Verification
REQ-035 Single write: req0, wr=1, addr word 0x0440 (byte 0x1100), data 0x00FFFFFF.
  - write_reg high exactly 3 cycles, busaddress=0x0440, busdata_in=0x00FFFFFF.
  - m_ack[0] at N+8; read_reg never high.
REQ-036 Single read: req1, wr=0, addr word 0x0448 (byte 0x1120), busdata_to_cpu=0x03020100 driven during WAIT.
  - m_ack[1] at N+8 with m_rdata=0x03020100.
REQ-037 Contention: both requesters request continuously from reset, each dropping req for one cycle after its ack.
  - Grant order is 1,0,1,0 (last_grant resets to 0).
  - One IDLE cycle between accesses; no overlapping strobes.
REQ-038 Reset mid-access: reset_in pulsed during the 2nd ISSUE cycle of a write.
  - write_reg falls in the same cycle and all outputs go to 0.
  - No m_ack; the next request after release is served normally.
REQ-039 Request withdrawn: req0 dropped one cycle after grant.
  - Access completes with the latched addr/data; m_ack[0] still issued at N+8.
REQ-040 Parameter sweep: StrobeCycles=1 with WaitCycles=1, and StrobeCycles=15 with WaitCycles=15.
  - Strobe width and m_ack latency (3 and 31 cycles) match REQ-025.
